// File: rtl/walksat_controller.sv
// WalkSAT flip sequencer: pops an unsat clause, evaluates each literal's break count,
// picks a variable (greedy or noisy random walk) and drives the flip handshake.
module walksat_controller #(
    parameter int unsigned NSAT                  = 3,
    parameter int unsigned NUM_VARIABLES         = 2048,
    parameter int unsigned NUM_CLAUSES           = 8192,
    parameter int unsigned MAX_CLAUSE_MEMBERSHIP = 20,
    parameter int unsigned FLIP_W                = 32,
    localparam int unsigned VAR_W = $clog2(NUM_VARIABLES),
    localparam int unsigned LIT_W = VAR_W + 1,
    localparam int unsigned CL_W  = $clog2(NUM_CLAUSES),
    localparam int unsigned BRK_W = $clog2(MAX_CLAUSE_MEMBERSHIP + 1)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start_i,
    input  logic                   abort_i,
    input  logic [FLIP_W-1:0]      max_flips_i,
    input  logic [7:0]             noise_i,
    input  logic [7:0]             rnd_noise_i,
    input  logic [7:0]             rnd_pick_i,
    input  logic                   ub_empty_i,
    output logic                   ub_pop_o,
    input  logic                   ub_valid_i,
    input  logic [CL_W-1:0]        ub_clause_i,
    output logic                   cl_req_o,
    output logic [CL_W-1:0]        cl_addr_o,
    input  logic                   cl_valid_i,
    input  logic [NSAT*LIT_W-1:0]  cl_lits_i,
    output logic                   brk_req_o,
    output logic [LIT_W-1:0]       brk_lit_o,
    input  logic                   brk_valid_i,
    input  logic [BRK_W-1:0]       brk_count_i,
    output logic                   flip_o,
    output logic [VAR_W-1:0]       flip_var_o,
    input  logic                   flip_done_i,
    output logic                   busy_o,
    output logic                   sat_o,
    output logic                   timeout_o,
    output logic [FLIP_W-1:0]      flip_count_o
);

    localparam int unsigned K_W = (NSAT > 1) ? $clog2(NSAT) : 1;

    typedef enum logic [3:0] {
        StIdle, StCheck, StPop, StFetch, StEval, StSelect, StFlip, StWaitFlip, StSat, StTimeout
    } state_t;

    state_t                 state_q, state_d;
    logic                   popped_q;
    logic [CL_W-1:0]        clause_q;
    logic [NSAT*LIT_W-1:0]  lits_q;
    logic [K_W-1:0]         k_q, argmin_q, sel_q, pick_k;
    logic [BRK_W-1:0]       min_q;
    logic [FLIP_W-1:0]      budget_q, flip_cnt_q;
    logic [7:0]             pick_raw;
    logic                   last_lit;

    assign pick_raw = rnd_pick_i % 8'(NSAT);
    assign pick_k   = K_W'(pick_raw);
    assign last_lit = (k_q == K_W'(NSAT - 1));

    always_comb begin
        state_d    = state_q;
        ub_pop_o   = 1'b0;
        cl_req_o   = 1'b0;
        cl_addr_o  = '0;
        brk_req_o  = 1'b0;
        brk_lit_o  = '0;
        flip_o     = 1'b0;
        flip_var_o = '0;
        busy_o     = 1'b1;
        unique case (state_q)
            StIdle, StSat, StTimeout: begin
                busy_o = 1'b0;
                if (start_i) state_d = StCheck;
            end
            StCheck: begin
                if (ub_empty_i)                  state_d = StSat;
                else if (flip_cnt_q == budget_q) state_d = StTimeout;
                else                             state_d = StPop;
            end
            StPop: begin
                ub_pop_o = ~popped_q;
                if (ub_valid_i) state_d = StFetch;
            end
            StFetch: begin
                cl_req_o  = 1'b1;
                cl_addr_o = clause_q;
                if (cl_valid_i) state_d = StEval;
            end
            StEval: begin
                brk_req_o = 1'b1;
                brk_lit_o = lits_q[32'(k_q)*LIT_W +: LIT_W];
                // A zero break count cannot be beaten, so skip the remaining literals.
                if (brk_valid_i && (brk_count_i == '0 || last_lit)) state_d = StSelect;
            end
            StSelect: state_d = StFlip;
            StFlip: begin
                flip_o     = 1'b1;
                flip_var_o = lits_q[32'(sel_q)*LIT_W + 1 +: VAR_W];
                state_d    = StWaitFlip;
            end
            StWaitFlip: begin
                flip_var_o = lits_q[32'(sel_q)*LIT_W + 1 +: VAR_W];
                if (flip_done_i) state_d = StCheck;
            end
            default: state_d = StIdle;
        endcase
        if (abort_i) state_d = StIdle;
    end

    assign sat_o        = (state_q == StSat);
    assign timeout_o    = (state_q == StTimeout);
    assign flip_count_o = flip_cnt_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= StIdle;
            popped_q   <= 1'b0;
            clause_q   <= '0;
            lits_q     <= '0;
            k_q        <= '0;
            argmin_q   <= '0;
            sel_q      <= '0;
            min_q      <= '0;
            budget_q   <= '0;
            flip_cnt_q <= '0;
        end else begin
            state_q  <= state_d;
            popped_q <= (state_q == StPop) && (state_d == StPop);
            if (abort_i) begin
                flip_cnt_q <= '0;
            end else begin
                case (state_q)
                    StIdle, StSat, StTimeout: begin
                        if (start_i) begin
                            flip_cnt_q <= '0;
                            budget_q   <= max_flips_i;
                        end
                    end
                    StPop: if (ub_valid_i) clause_q <= ub_clause_i;
                    StFetch: begin
                        if (cl_valid_i) begin
                            lits_q <= cl_lits_i;
                            k_q    <= '0;
                        end
                    end
                    StEval: begin
                        if (brk_valid_i) begin
                            if (k_q == '0 || brk_count_i < min_q) begin
                                min_q    <= brk_count_i;
                                argmin_q <= k_q;
                            end
                            k_q <= k_q + 1'b1;
                        end
                    end
                    StSelect: begin
                        sel_q <= (min_q != '0 && rnd_noise_i < noise_i) ? pick_k : argmin_q;
                    end
                    StWaitFlip: begin
                        if (flip_done_i && flip_cnt_q != '1) flip_cnt_q <= flip_cnt_q + 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_walksat_controller.sv
// Scoreboard bench for walksat_controller: a randomized datapath responder serves clauses
// and break counts from a record table; expected flips come from a high-level pick model.
module tb_walksat_controller;

    localparam int NSAT = 3, VAR_W = 11, LIT_W = 12, CL_W = 13, BRK_W = 5, FLIP_W = 32;

    typedef struct packed {
        logic [NSAT*LIT_W-1:0] lits;
        logic [NSAT*BRK_W-1:0] brks;
        logic [7:0]            noise;
        logic [7:0]            rn;
        logic [7:0]            rp;
    } rec_t;

    logic clk = 1'b0, reset;
    logic start_i, abort_i, ub_empty_i, ub_valid_i, cl_valid_i, brk_valid_i, flip_done_i;
    logic [FLIP_W-1:0] max_flips_i;
    logic [7:0] noise_i, rnd_noise_i, rnd_pick_i;
    logic [CL_W-1:0] ub_clause_i, cl_addr_o;
    logic [NSAT*LIT_W-1:0] cl_lits_i;
    logic [BRK_W-1:0] brk_count_i;
    logic ub_pop_o, cl_req_o, brk_req_o, flip_o, busy_o, sat_o, timeout_o;
    logic [LIT_W-1:0] brk_lit_o;
    logic [VAR_W-1:0] flip_var_o;
    logic [FLIP_W-1:0] flip_count_o;

    always #5 clk = ~clk;

    walksat_controller dut (
        .clk(clk), .reset(reset), .start_i(start_i), .abort_i(abort_i),
        .max_flips_i(max_flips_i), .noise_i(noise_i), .rnd_noise_i(rnd_noise_i),
        .rnd_pick_i(rnd_pick_i), .ub_empty_i(ub_empty_i), .ub_pop_o(ub_pop_o),
        .ub_valid_i(ub_valid_i), .ub_clause_i(ub_clause_i), .cl_req_o(cl_req_o),
        .cl_addr_o(cl_addr_o), .cl_valid_i(cl_valid_i), .cl_lits_i(cl_lits_i),
        .brk_req_o(brk_req_o), .brk_lit_o(brk_lit_o), .brk_valid_i(brk_valid_i),
        .brk_count_i(brk_count_i), .flip_o(flip_o), .flip_var_o(flip_var_o),
        .flip_done_i(flip_done_i), .busy_o(busy_o), .sat_o(sat_o), .timeout_o(timeout_o),
        .flip_count_o(flip_count_o)
    );

    int checks = 0, failures = 0;
    rec_t recs [0:63];
    int n_recs = 0, it = 0, brk_k = 0, n_pop = 0, n_flip = 0, run_flips = 0;
    int last_clause = 0;
    bit pop_pend = 0, fd_pend = 0;
    int exp_var_q[$];
    int exp_nbrk_q[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // Reference pick: a zero break wins outright, otherwise noise walk or first minimum.
    function automatic void model(input rec_t r, output int var_o, output int nb);
        int b[NSAT];
        int mn = 1000;
        int pick = -1;
        for (int k = 0; k < NSAT; k++) b[k] = int'(r.brks[k*BRK_W +: BRK_W]);
        for (int k = 0; k < NSAT; k++)
            if (pick < 0 && b[k] == 0) begin pick = k; nb = k + 1; end
        if (pick < 0) begin
            nb = NSAT;
            for (int k = 0; k < NSAT; k++) if (b[k] < mn) mn = b[k];
            if (r.rn < r.noise) pick = int'(r.rp) % NSAT;
            else for (int k = 0; k < NSAT; k++) if (pick < 0 && b[k] == mn) pick = k;
        end
        var_o = int'(r.lits[pick*LIT_W +: LIT_W]) >> 1;
    endfunction

    function automatic rec_t mk(input int l0, l1, l2, b0, b1, b2, nz, rn, rp);
        rec_t r;
        r.lits  = {LIT_W'(l2), LIT_W'(l1), LIT_W'(l0)};
        r.brks  = {BRK_W'(b2), BRK_W'(b1), BRK_W'(b0)};
        r.noise = 8'(nz); r.rn = 8'(rn); r.rp = 8'(rp);
        return r;
    endfunction

    function automatic rec_t rnd_rec();
        int v0, v1, v2, nz;
        v0 = $urandom_range(0, 2047);
        v1 = (v0 + 1 + $urandom_range(0, 600)) % 2048;
        v2 = (v1 + 1 + $urandom_range(0, 600)) % 2048;
        case ($urandom_range(0, 2))
            0: nz = 0;
            1: nz = 255;
            default: nz = $urandom_range(0, 255);
        endcase
        return mk(v0*2 + $urandom_range(0, 1), v1*2 + $urandom_range(0, 1),
                  v2*2 + $urandom_range(0, 1), $urandom_range(0, 4), $urandom_range(0, 4),
                  $urandom_range(0, 4), nz, $urandom_range(0, 255), $urandom_range(0, 255));
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic arm(input int n, input longint budget);
        int v, nb;
        it = 0; brk_k = 0; pop_pend = 0; fd_pend = 0;
        n_pop = 0; n_flip = 0; run_flips = 0; n_recs = n;
        exp_var_q.delete(); exp_nbrk_q.delete();
        for (int i = 0; i < n && longint'(i) < budget; i++) begin
            model(recs[i], v, nb);
            exp_var_q.push_back(v);
            exp_nbrk_q.push_back(nb);
        end
    endtask

    task automatic start_run(input logic [FLIP_W-1:0] budget);
        max_flips_i = budget;
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
    endtask

    task automatic wait_end();
        int n = 0;
        while (!(sat_o || timeout_o) && n < 3000) begin tick(); n++; end
        if (n >= 3000) begin
            checks++; failures++;
            $display("FAIL run_end_timeout actual=busy required=sat_or_timeout");
        end
    endtask

    task automatic check_end(input string tag, input bit sat, input int cnt);
        chk({tag, "_sat"}, sat_o, sat);
        chk({tag, "_timeout"}, timeout_o, !sat);
        chk({tag, "_count"}, flip_count_o, cnt);
        chk({tag, "_pending_flips"}, exp_var_q.size(), 0);
    endtask

    // Datapath responder: random handshake delays plus stray valids outside requests.
    initial begin
        int pop_dly = 0, cl_dly = 0, brk_dly = 0, fd_dly = 0, ri;
        {ub_valid_i, cl_valid_i, brk_valid_i, flip_done_i} = '0;
        ub_empty_i = 1'b1; noise_i = '0; rnd_noise_i = '0; rnd_pick_i = '0;
        ub_clause_i = '0; cl_lits_i = '0; brk_count_i = '0;
        forever begin
            @(negedge clk);
            ri = (it < 64) ? it : 63;
            ub_empty_i  = (it >= n_recs);
            noise_i     = recs[ri].noise;
            rnd_noise_i = recs[ri].rn;
            rnd_pick_i  = recs[ri].rp;
            {ub_valid_i, cl_valid_i, brk_valid_i, flip_done_i} = '0;
            ub_clause_i = CL_W'($urandom);
            cl_lits_i   = {4'($urandom), $urandom};
            brk_count_i = BRK_W'($urandom);
            if (pop_pend) begin
                if (pop_dly == 0) begin
                    ub_valid_i = 1'b1; last_clause = int'(ub_clause_i); pop_pend = 0;
                end else pop_dly--;
            end
            if (ub_pop_o) begin
                n_pop++;
                pop_dly = $urandom_range(0, 2);
                if (pop_dly == 0) begin
                    ub_valid_i = 1'b1; last_clause = int'(ub_clause_i);
                end else begin
                    pop_pend = 1; pop_dly--;
                end
            end
            if (cl_req_o) begin
                if (cl_dly == 0) begin
                    cl_valid_i = 1'b1;
                    cl_lits_i  = recs[ri].lits;
                    chk("cl_addr", cl_addr_o, last_clause);
                    cl_dly = $urandom_range(0, 2);
                end else cl_dly--;
            end else if ($urandom_range(0, 7) == 0) cl_valid_i = 1'b1;
            if (brk_req_o) begin
                if (brk_dly == 0) begin
                    chk("brk_in_range", brk_k < NSAT, 1);
                    if (brk_k < NSAT) begin
                        chk("brk_lit", brk_lit_o, recs[ri].lits[brk_k*LIT_W +: LIT_W]);
                        brk_count_i = recs[ri].brks[brk_k*BRK_W +: BRK_W];
                    end
                    brk_valid_i = 1'b1;
                    brk_k++;
                    brk_dly = $urandom_range(0, 2);
                end else brk_dly--;
            end else if ($urandom_range(0, 7) == 0) begin
                brk_valid_i = 1'b1; brk_count_i = '0;
            end
            if (fd_pend) begin
                if (fd_dly == 0) begin
                    flip_done_i = 1'b1; fd_pend = 0; it++; brk_k = 0;
                end else fd_dly--;
            end
            if (flip_o) begin fd_pend = 1; fd_dly = $urandom_range(0, 2); end
        end
    end

    // Monitor: every flip pulse is scored against the next expected pick.
    initial begin
        forever begin
            @(negedge clk);
            if (flip_o) begin
                n_flip++;
                if (exp_var_q.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL flip_unexpected actual=var%0d required=no_flip", flip_var_o);
                end else begin
                    chk("flip_var", flip_var_o, exp_var_q.pop_front());
                    chk("brk_reqs", brk_k, exp_nbrk_q.pop_front());
                    chk("flip_count_before", flip_count_o, run_flips);
                end
                run_flips++;
            end
        end
    end

    initial begin
        int n;
        reset = 1'b1; start_i = 1'b0; abort_i = 1'b0; max_flips_i = '0;
        for (int i = 0; i < 64; i++) recs[i] = rnd_rec();
        repeat (3) tick();
        chk("rst_busy", busy_o, 0);
        chk("rst_sat", sat_o, 0);
        chk("rst_timeout", timeout_o, 0);
        chk("rst_count", flip_count_o, 0);
        chk("rst_pop", ub_pop_o, 0);
        chk("rst_flip", flip_o, 0);
        reset = 1'b0;
        tick();

        // Empty buffer: SAT two cycles after start, no pop.
        arm(0, 0);
        start_run(100);
        chk("sat0_busy_check", busy_o, 1);
        chk("sat0_sat_early", sat_o, 0);
        tick();
        chk("sat0_sat", sat_o, 1);
        chk("sat0_busy", busy_o, 0);
        chk("sat0_count", flip_count_o, 0);
        chk("sat0_pops", n_pop, 0);

        // Zero budget with work pending: immediate timeout.
        arm(5, 0);
        start_run(0);
        tick();
        chk("to0_timeout", timeout_o, 1);
        chk("to0_sat", sat_o, 0);
        repeat (5) tick();
        chk("to0_pops", n_pop, 0);
        chk("to0_flips", n_flip, 0);

        // Directed picks: greedy, early zero exit, noise walk, noise off.
        recs[0] = mk(10, 21, 33, 3, 1, 2, 0, 0, 0);
        recs[1] = mk(100, 203, 306, 2, 0, 7, 255, 0, 1);
        recs[2] = mk(40, 51, 62, 1, 1, 1, 255, 0, 5);
        recs[3] = mk(40, 51, 62, 1, 1, 1, 0, 0, 5);
        arm(4, 1000);
        chk("dir_first_var", exp_var_q[0], 10);
        start_run(1000);
        wait_end();
        check_end("dir", 1, 4);
        chk("dir_pops", n_pop, 4);

        // Abort during EVAL beats a simultaneous start.
        for (int i = 0; i < 8; i++) recs[i] = rnd_rec();
        arm(5, 1000);
        start_run(1000);
        n = 0;
        while (!brk_req_o && n < 200) begin tick(); n++; end
        chk("abort_saw_brk_req", brk_req_o, 1);
        abort_i = 1'b1; start_i = 1'b1;
        tick();
        abort_i = 1'b0; start_i = 1'b0;
        chk("abort_busy", busy_o, 0);
        chk("abort_brk_req", brk_req_o, 0);
        chk("abort_count", flip_count_o, 0);
        repeat (6) tick();
        chk("abort_no_flip", n_flip, 0);
        chk("abort_still_idle", busy_o, 0);
        arm(3, 1000);
        start_run(1000);
        wait_end();
        check_end("post_abort", 1, 3);

        // Budget of 7 with 20 clauses; a start pulse mid-run must be ignored.
        for (int i = 0; i < 20; i++) recs[i] = rnd_rec();
        arm(20, 7);
        start_run(7);
        repeat (15) tick();
        max_flips_i = '0; start_i = 1'b1;
        tick();
        start_i = 1'b0;
        wait_end();
        check_end("budget7", 0, 7);

        // All-ones budget must never time out early.
        for (int i = 0; i < 12; i++) recs[i] = rnd_rec();
        arm(12, 64'h0000_0000_FFFF_FFFF);
        start_run('1);
        wait_end();
        check_end("budget_max", 1, 12);

        // Random runs.
        for (int r = 0; r < 4; r++) begin
            int nr, bud;
            nr  = $urandom_range(1, 10);
            bud = $urandom_range(0, 12);
            for (int i = 0; i < nr; i++) recs[i] = rnd_rec();
            arm(nr, bud);
            start_run(FLIP_W'(bud));
            wait_end();
            check_end("rnd", nr <= bud, (nr <= bud) ? nr : bud);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
